// File: rtl/output_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : output_stage_pkg
//  Purpose  : Shared constants, entry field offsets and state encoding for
//             the serial word-link frame transmitter (and its receive path).
//  Revision : 1.0  initial release
// ============================================================================
package output_stage_pkg;

    // Packed FIFO entry: {data[127:0] left-aligned, ch_sel[7:0], word_cnt[3:0]}
    localparam int unsigned c_ENTRY_W   = 140;
    localparam int unsigned c_DATA_MSB  = 139;
    localparam int unsigned c_DATA_W    = 128;
    localparam int unsigned c_CH_LSB    = 4;
    localparam int unsigned c_CH_W      = 8;
    localparam int unsigned c_CNT_LSB   = 0;
    localparam int unsigned c_CNT_W     = 4;

    // Largest payload that fits in the 128-bit data field
    localparam logic [3:0]  c_MAX_WORDS = 4'd8;

    // Framing words
    localparam logic [15:0] c_HDR_WORD  = 16'hE0E0;
    localparam logic [15:0] c_TRL_WORD  = 16'h0E0E;
    localparam logic [15:0] c_IDLE_WORD = 16'h0000;

    // CRC-16, MSB-first, no reflection
    localparam logic [15:0] c_CRC16_POLY = 16'h1021;

    // Each state is named after the word currently on data_out
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_HDR0  = 4'd2,
        ST_HDR1  = 4'd3,
        ST_CHAN  = 4'd4,
        ST_DATA  = 4'd5,
        ST_CRC   = 4'd6,
        ST_TRL0  = 4'd7,
        ST_TRL1  = 4'd8,
        ST_GAP   = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/output_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : output_stage_if
//  Purpose  : Read port of the output FIFO. The transmitter is the master
//             (issues read strobes); the FIFO is the slave.
//  Revision : 1.0  initial release
// ============================================================================
interface output_stage_if;
    import output_stage_pkg::*;

    logic                 fifo_empty;
    logic                 fifo_r_enable;
    logic [c_ENTRY_W-1:0] data_from_fifo;

    modport master (
        input  fifo_empty,
        input  data_from_fifo,
        output fifo_r_enable
    );

    modport slave (
        output fifo_empty,
        output data_from_fifo,
        input  fifo_r_enable
    );

endinterface
`default_nettype wire

// File: rtl/output_stage_crc16_step.sv
`default_nettype none
// ============================================================================
//  Module   : crc16_step
//  Purpose  : One 16-bit word of CRC-16 (poly 0x1021), MSB-first, purely
//             combinational. Shared with the receive path.
//  Revision : 1.0  initial release
// ============================================================================
module crc16_step
    import output_stage_pkg::*;
(
    input  wire logic [15:0] crc_in,
    input  wire logic [15:0] word,
    output logic      [15:0] crc_out
);

    logic [15:0] w_crc;

    // Bit-serial division unrolled over the 16 word bits, MSB first
    always_comb begin
        w_crc = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (w_crc[15] ^ word[i]) begin
                w_crc = {w_crc[14:0], 1'b0} ^ c_CRC16_POLY;
            end else begin
                w_crc = {w_crc[14:0], 1'b0};
            end
        end
        crc_out = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/output_stage.sv
`default_nettype none
// ============================================================================
//  Module   : output_stage
//  Purpose  : Pops one 140-bit entry from the output FIFO and serialises it
//             as {HDR,HDR,channel,data[0..N-1],CRC,TRL,TRL}, one word per
//             clock, with an idle gap between frames.
//  Revision : 1.0  initial release
// ============================================================================
module output_stage
    import output_stage_pkg::*;
#(
    parameter int unsigned GAP_WORDS = 2
)
(
    input  wire logic        clk_in,
    input  wire logic        rst,
    output_stage_if.master   fifo,
    output logic      [15:0] data_out,
    output logic             tx_busy,
    output logic             len_err
);

    localparam int unsigned         c_GAP_CW   = (GAP_WORDS > 1) ? $clog2(GAP_WORDS) : 1;
    localparam logic [c_GAP_CW-1:0] c_GAP_LOAD = c_GAP_CW'(GAP_WORDS - 1);

    state_t                r_state,    w_state;
    logic [c_DATA_W-1:0]   r_shift,    w_shift;
    logic [c_CH_W-1:0]     r_ch,       w_ch;
    logic [c_CNT_W-1:0]    r_left,     w_left;
    logic [15:0]           r_crc,      w_crc;
    logic [c_GAP_CW-1:0]   r_gap,      w_gap;
    logic [15:0]           r_data_out, w_data_out;
    logic                  r_len_err,  w_len_err;
    logic                  w_rd;
    logic                  w_busy;
    logic [15:0]           w_crc_next;
    logic [15:0]           w_top_word;
    logic [c_CNT_W-1:0]    w_fetch_cnt;
    logic                  w_fetch_bad;

    assign w_top_word  = r_shift[c_DATA_W-1 -: 16];
    assign w_fetch_cnt = fifo.data_from_fifo[c_CNT_LSB +: c_CNT_W];
    assign w_fetch_bad = (w_fetch_cnt == '0) || (w_fetch_cnt > c_MAX_WORDS);

    crc16_step u_crc16_step (
        .crc_in  (r_crc),
        .word    (w_top_word),
        .crc_out (w_crc_next)
    );

    // Next-state and next-output decode; data_out is loaded with the word
    // belonging to the state being entered so it stays fully registered.
    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_ch       = r_ch;
        w_left     = r_left;
        w_crc      = r_crc;
        w_gap      = r_gap;
        w_data_out = c_IDLE_WORD;
        w_len_err  = 1'b0;
        w_rd       = 1'b0;
        w_busy     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Gated by rst so no strobe escapes while reset is held
                if (!fifo.fifo_empty && (r_gap == '0) && !rst) begin
                    w_rd    = 1'b1;
                    w_busy  = 1'b1;
                    w_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_busy  = 1'b1;
                w_shift = fifo.data_from_fifo[c_DATA_MSB -: c_DATA_W];
                w_ch    = fifo.data_from_fifo[c_CH_LSB +: c_CH_W];
                w_left  = w_fetch_cnt - 4'd1;
                w_crc   = '0;
                if (w_fetch_bad) begin
                    w_len_err = 1'b1;
                    w_gap     = c_GAP_LOAD;
                    w_state   = ST_GAP;
                end else begin
                    w_data_out = c_HDR_WORD;
                    w_state    = ST_HDR0;
                end
            end
            ST_HDR0: begin
                w_busy     = 1'b1;
                w_data_out = c_HDR_WORD;
                w_state    = ST_HDR1;
            end
            ST_HDR1: begin
                w_busy     = 1'b1;
                w_data_out = {8'h00, r_ch};
                w_state    = ST_CHAN;
            end
            ST_CHAN: begin
                w_busy     = 1'b1;
                w_data_out = w_top_word;
                w_shift    = r_shift << 16;
                w_crc      = w_crc_next;
                w_state    = ST_DATA;
            end
            ST_DATA: begin
                w_busy = 1'b1;
                if (r_left == '0) begin
                    w_data_out = r_crc;
                    w_state    = ST_CRC;
                end else begin
                    w_data_out = w_top_word;
                    w_shift    = r_shift << 16;
                    w_crc      = w_crc_next;
                    w_left     = r_left - 4'd1;
                end
            end
            ST_CRC: begin
                w_busy     = 1'b1;
                w_data_out = c_TRL_WORD;
                w_state    = ST_TRL0;
            end
            ST_TRL0: begin
                w_busy     = 1'b1;
                w_data_out = c_TRL_WORD;
                w_state    = ST_TRL1;
            end
            ST_TRL1: begin
                w_busy  = 1'b1;
                w_gap   = c_GAP_LOAD;
                w_state = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap == '0) begin
                    w_state = ST_IDLE;
                end else begin
                    w_gap = r_gap - 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_ch       <= '0;
            r_left     <= '0;
            r_crc      <= '0;
            r_gap      <= '0;
            r_data_out <= c_IDLE_WORD;
            r_len_err  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_ch       <= w_ch;
            r_left     <= w_left;
            r_crc      <= w_crc;
            r_gap      <= w_gap;
            r_data_out <= w_data_out;
            r_len_err  <= w_len_err;
        end
    end

    assign fifo.fifo_r_enable = w_rd;
    assign tx_busy            = w_busy;
    assign data_out           = r_data_out;
    assign len_err            = r_len_err;

endmodule
`default_nettype wire
